// File: rtl/apb_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the APB instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_ADDR_W = 8;
    localparam int FETCH_DATA_W = 16;

    typedef enum logic [1:0] {
        SETUP  = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        ERR    = 2'd3
    } fetch_state_t;

    // Opcode lives in word[15:12]; only OP_IMM changes fetch behaviour
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_IMM = 4'h3;

endpackage
`default_nettype wire

// File: rtl/apb_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_fetch_unit_if
// Purpose  : APB read port, instruction handshake and redirect bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
);

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    logic              ins_valid;
    logic              ins_ready;
    logic [DATA_W-1:0] ins_word;
    logic [DATA_W-1:0] ins_imm;
    logic              ins_has_imm;
    logic [ADDR_W-1:0] ins_pc;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              fetch_err;

    // Fetch unit side
    modport master (
        output paddr, psel, penable, pwrite,
        input  prdata, pready, pslverr,
        output ins_valid, ins_word, ins_imm, ins_has_imm, ins_pc,
        input  ins_ready,
        input  redirect, redirect_pc,
        output fetch_err
    );

    // Memory / processor side
    modport slave (
        input  paddr, psel, penable, pwrite,
        output prdata, pready, pslverr,
        input  ins_valid, ins_word, ins_imm, ins_has_imm, ins_pc,
        output ins_ready,
        output redirect, redirect_pc,
        input  fetch_err
    );

endinterface
`default_nettype wire

// File: rtl/apb_fetch_unit_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : apb_rd_port
// Purpose  : Single-read APB master; owns psel/penable/paddr, reports done/err.
// Revision : 1.0 - initial release
// ============================================================================
module apb_rd_port #(
    parameter int              ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] start_addr,
    input  wire logic              pready,
    input  wire logic              pslverr,
    output logic                   psel,
    output logic                   penable,
    output logic [ADDR_W-1:0]      paddr,
    output logic                   done,
    output logic                   err
);

    logic              r_psel;
    logic              r_penable;
    logic [ADDR_W-1:0] r_paddr;

    // Reset parks the port in the setup phase of a read at RESET_ADDR, so the
    // first fetch is on the bus in the very first cycle after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= RESET_ADDR;
        end else if (start) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= start_addr;
        end else if (r_psel && !r_penable) begin
            r_penable <= 1'b1;
        end else if (done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end
    end

    // Gating with rst_n drops the bus to idle in the same cycle reset asserts
    assign psel    = r_psel & rst_n;
    assign penable = r_penable & rst_n;
    assign paddr   = r_paddr;

    assign done = r_psel & r_penable & pready;
    assign err  = done & pslverr;

endmodule
`default_nettype wire

// File: rtl/apb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : apb_fetch_unit
// Purpose  : APB instruction fetch with two-word (opcode + immediate) assembly,
//            valid/ready delivery, PC redirect and sticky slave-error halt.
//            Define APB_FETCH_IMM_EN to enable two-word assembly.
// Revision : 1.0 - initial release
// ============================================================================
module apb_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = FETCH_ADDR_W,
    parameter int                DATA_W     = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]        IMM_OPCODE = OP_IMM
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    apb_fetch_unit_if.master bus
);

    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_HOLD   = HOLD;
    localparam logic [1:0] ST_ERR    = ERR;

    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_redir_pend;
    logic [ADDR_W-1:0] r_redir_pc;
    logic              r_fetch_err;
    logic [DATA_W-1:0] r_ins_word;
    logic [ADDR_W-1:0] r_ins_pc;

    logic              w_start;
    logic [ADDR_W-1:0] w_start_addr;
    logic              w_done;
    logic              w_err;
    logic              w_redir_any;
    logic [ADDR_W-1:0] w_redir_tgt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_deliver_ok;
    logic              w_first_imm;
    logic              w_second;
    logic              w_capture_first;

    apb_rd_port #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (RESET_PC)
    ) u_rd_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_start),
        .start_addr (w_start_addr),
        .pready     (bus.pready),
        .pslverr    (bus.pslverr),
        .psel       (bus.psel),
        .penable    (bus.penable),
        .paddr      (bus.paddr),
        .done       (w_done),
        .err        (w_err)
    );

    // A redirect seen during ACCESS is parked until the transfer completes
    assign w_redir_any  = r_redir_pend | bus.redirect;
    assign w_redir_tgt  = bus.redirect ? bus.redirect_pc : r_redir_pc;
    assign w_pc_inc     = r_pc + c_pc_one;
    assign w_deliver_ok = w_done & ~w_err & ~w_redir_any;

    assign w_capture_first = (r_state == ST_ACCESS) & w_deliver_ok & ~w_second;

    always_comb begin
        w_start      = 1'b0;
        w_start_addr = r_pc;
        case (r_state)
            ST_SETUP: begin
                if (bus.redirect) begin
                    w_start      = 1'b1;
                    w_start_addr = bus.redirect_pc;
                end
            end
            ST_ACCESS: begin
                if (w_done && !w_err) begin
                    if (w_redir_any) begin
                        w_start      = 1'b1;
                        w_start_addr = w_redir_tgt;
                    end else if (w_first_imm) begin
                        w_start      = 1'b1;
                        w_start_addr = w_pc_inc;
                    end
                end
            end
            ST_HOLD: begin
                // Redirect and acceptance together: instruction consumed, redirect owns the PC
                if (bus.redirect) begin
                    w_start      = 1'b1;
                    w_start_addr = bus.redirect_pc;
                end else if (bus.ins_ready) begin
                    w_start      = 1'b1;
                    w_start_addr = w_pc_inc;
                end
            end
            ST_ERR: begin
                if (bus.redirect) begin
                    w_start      = 1'b1;
                    w_start_addr = bus.redirect_pc;
                end
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_SETUP;
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= RESET_PC;
            r_fetch_err  <= 1'b0;
            r_ins_word   <= '0;
            r_ins_pc     <= RESET_PC;
        end else begin
            case (r_state)
                ST_SETUP: begin
                    if (!bus.redirect) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_redir_pend <= 1'b0;
                        if (w_err) begin
                            r_state     <= ST_ERR;
                            r_fetch_err <= 1'b1;
                        end else if (w_redir_any || w_first_imm) begin
                            r_state <= ST_SETUP;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end else if (bus.redirect) begin
                        r_redir_pend <= 1'b1;
                        r_redir_pc   <= bus.redirect_pc;
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect || bus.ins_ready) begin
                        r_state <= ST_SETUP;
                    end
                end
                ST_ERR: begin
                    if (bus.redirect) begin
                        r_state     <= ST_SETUP;
                        r_fetch_err <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_SETUP;
                end
            endcase

            if (w_start) begin
                r_pc <= w_start_addr;
            end

            if (w_capture_first) begin
                r_ins_word <= bus.prdata;
                r_ins_pc   <= r_pc;
            end
        end
    end

`ifdef APB_FETCH_IMM_EN
    logic              r_second;
    logic              r_has_imm;
    logic [DATA_W-1:0] r_imm;

    assign w_second    = r_second;
    assign w_first_imm = ~r_second & (bus.prdata[DATA_W-1 -: 4] == IMM_OPCODE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_second  <= 1'b0;
            r_has_imm <= 1'b0;
            r_imm     <= '0;
        end else if (r_state == ST_ACCESS && w_done) begin
            r_second <= w_deliver_ok & w_first_imm;
            if (w_deliver_ok && r_second) begin
                r_imm     <= bus.prdata;
                r_has_imm <= 1'b1;
            end else if (w_deliver_ok && !w_first_imm) begin
                r_imm     <= '0;
                r_has_imm <= 1'b0;
            end
        end else if (bus.redirect) begin
            r_second <= 1'b0;
        end
    end

    assign bus.ins_imm     = r_imm;
    assign bus.ins_has_imm = r_has_imm;
`else
    logic w_unused_imm_opcode;

    assign w_second            = 1'b0;
    assign w_first_imm         = 1'b0;
    assign w_unused_imm_opcode = ^IMM_OPCODE;
    assign bus.ins_imm         = '0;
    assign bus.ins_has_imm     = 1'b0;
`endif

    assign bus.pwrite    = 1'b0;
    assign bus.ins_valid = (r_state == ST_HOLD);
    assign bus.ins_word  = r_ins_word;
    assign bus.ins_pc    = r_ins_pc;
    assign bus.fetch_err = r_fetch_err;

endmodule
`default_nettype wire

// File: doc/apb_fetch_unit.md
# apb_fetch_unit

Instruction fetch stage sitting directly upstream of `processor`. It reads 16-bit program words from program memory over an APB master port and assembles two-word instructions: opcode 0x3 followed by an immediate operand word. It presents each complete instruction to the processor through a valid/ready handshake and supports PC redirect for jumps.

## Interface
Parameters:
- `ADDR_W`, 8: program address width, matching the 256-entry program memory.
- `DATA_W`, 16: instruction/data word width.
- `RESET_PC`, 0: fetch address after reset.
- `IMM_OPCODE`, 4'h3: value of `word[15:12]` that marks an instruction carrying a following immediate word.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `paddr` out ADDR_W: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: constant 0 (read-only master).
- `prdata` in DATA_W: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.
- `ins_valid` out 1: instruction available.
- `ins_ready` in 1: processor accepts the instruction.
- `ins_word` out DATA_W: opcode word.
- `ins_imm` out DATA_W: immediate word; 0 when none.
- `ins_has_imm` out 1: `ins_imm` is meaningful.
- `ins_pc` out ADDR_W: address of `ins_word`.
- `redirect` in 1: load a new PC, discarding in-flight work.
- `redirect_pc` in ADDR_W: target PC.
- `fetch_err` out 1: sticky slave error flag.

## Operation
- **States:**
  - `SETUP`: `psel`=1, `penable`=0.
  - `ACCESS`: `psel`=1, `penable`=1, wait for `pready`.
  - `HOLD`: `ins_valid`=1.
  - `ERR`: halted.
- **Sequencing:**
  - `SETUP` → `ACCESS` unconditionally.
  - `ACCESS` with `pready`=0 → stay in `ACCESS`.
  - `ACCESS` with `pready`=1, first word, `prdata[15:12]`==`IMM_OPCODE` → latch `ins_word`, PC+1, go to `SETUP` for the operand.
  - `ACCESS` with `pready`=1, first word, other opcode → latch `ins_word`, `ins_has_imm`=0, `ins_imm`=0, go to `HOLD`.
  - `ACCESS` with `pready`=1, operand word → latch `ins_imm`, `ins_has_imm`=1, go to `HOLD`.
- **Handshake:**
  - `ins_valid` and all `ins_*` outputs are stable while in `HOLD` until `ins_valid` & `ins_ready`.
  - On acceptance: PC+1, go to `SETUP`.
  - `ins_ready` is ignored outside `HOLD`.
- **PC arithmetic:** ADDR_W-bit modulo, so 0xFF+1 = 0x00. An opcode at 0xFF takes its operand from 0x00.
- **Redirect:**
  - In `SETUP` or `HOLD`: PC ← `redirect_pc`, drop the held instruction, go to `SETUP`.
  - In `ACCESS`: the APB transfer is never aborted. Record the pending redirect, complete the transfer, discard its data, then go to `SETUP` at `redirect_pc`.
  - A redirect arriving in the same cycle as acceptance in `HOLD`: the instruction counts as consumed, and the redirect wins the PC update.
- **Error:**
  - `pslverr`=1 with `pready`=1 sets `fetch_err` (sticky), discards the data, and enters `ERR`.
  - `ERR` issues no APB traffic and keeps `ins_valid`=0.
  - Only `redirect` exits `ERR` (to `SETUP`) and clears `fetch_err`.
- **Reset mid-transfer:** all state is cleared on the next edge with `rst_n`=0; the APB bus returns to idle immediately.

## Timing
- **Reset values:**
  - `psel`, `penable`, `pwrite`: 0.
  - `paddr`: `RESET_PC`.
  - `ins_valid`, `ins_has_imm`, `fetch_err`: 0.
  - `ins_word`, `ins_imm`: 0.
  - `ins_pc`: `RESET_PC`.
  - State `SETUP` on the first edge with `rst_n`=1.
- **Single-word latency, zero wait states:** `SETUP` in cycle n, `ACCESS` in n+1, `ins_valid`=1 in n+2.
- **Two-word latency:** `ins_valid`=1 in n+4.
- **Wait states:** each `pready`=0 cycle adds one cycle.
- **Throughput:** acceptance in the first `HOLD` cycle gives `SETUP` in the next cycle, i.e. 3 cycles per single-word instruction and 5 per two-word instruction.
- **Redirect:** `redirect` in cycle k (not in `ACCESS`) gives `SETUP` with `paddr`=`redirect_pc` in k+1.

## Configuration
- `APB_FETCH_IMM_EN` defined: two-word assembly as described above.
- `APB_FETCH_IMM_EN` undefined:
  - Every word is a complete instruction, so `ACCESS` always goes to `HOLD`.
  - `ins_has_imm` and `ins_imm` are tied to 0.
  - `IMM_OPCODE` is unused.

## Structure
- **`fetch_pkg`:**
  - State enum `fetch_state_t` with values `SETUP`, `ACCESS`, `HOLD`, `ERR`.
  - Opcode constants `OP_IMM`=4'h3, `OP_ADD`, `OP_SUB`.
  - `FETCH_ADDR_W` and `FETCH_DATA_W` defaults.
- **Sub-module `apb_rd_port`:** a generic single-read APB master (request/done/err) that owns `psel`/`penable`/`paddr`.
- **`apb_fetch_unit`:** owns the PC, the assembly FSM, the output register and redirect tracking.

## Test plan
- **Reset:** memory [0]=0x0000; release `rst_n`; `ins_ready`=1 → `ins_valid` in cycle 2 with `ins_word`=0x0000, `ins_pc`=0x00, `ins_has_imm`=0.
- **Two-word instruction:** memory [0]=0x3000, [1]=0x0001, [2]=0x3001, [3]=0x0003 → `ins_word`=0x3000, `ins_imm`=0x0001, `ins_pc`=0; then 0x3001 / 0x0003, `ins_pc`=2. Exactly 4 APB reads.
- **Backpressure and wait states:** `ins_ready` low for 4 cycles and `pready` low for 2 → outputs stable while held; paddr sequence 0, 1, 2 with no skipped or duplicated reads.
- **Wrap-around:** redirect to 0xFF; [0xFF]=0x3005, [0x00]=0x00AA → `ins_imm`=0x00AA, `ins_pc`=0xFF; next fetch at 0x01.
- **Redirect during `ACCESS`:** `redirect_pc`=0x40 with `pready` delayed → current transfer completes, its data is discarded, next `paddr`=0x40, and no `ins_valid` for the old address.
- **Slave error:** `pslverr`=1 on the read at 0x05 → `fetch_err`=1, `psel` stays 0 and `ins_valid` stays 0 for 10 cycles; redirect to 0x00 clears `fetch_err` and resumes fetching.
